column_round_ctrl: RTL and testbench

COLUMN_ROUND_CTRL -- requirements
Module: column_round_ctrl

---
 rtl/column_round_ctrl_if.sv | 31 +++
 rtl/column_round_ctrl.sv | 124 ++++++++++++
 tb/tb_column_round_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/column_round_ctrl_if.sv
// Bus bundle for column_round_ctrl: job request, Column-stage loop and result handshake.
// The master modport is the environment side; the slave modport is the controller.
interface column_round_ctrl_if #(
    parameter int MAX_ROUNDS = 8
);
    localparam int RW = $clog2(MAX_ROUNDS);

    logic                      start;
    logic [127:0]              data_in;
    logic [2*MAX_ROUNDS-1:0]   key;
    logic [RW-1:0]             rounds;
    logic [127:0]              col_in;
    logic [127:0]              col_out;
    logic                      sel_s3;
    logic                      sel_s4;
    logic                      busy;
    logic                      out_valid;
    logic                      out_ready;
    logic [127:0]              data_out;
    logic [RW-1:0]             round_idx;

    modport slave (
        input  start, data_in, key, rounds, col_out, out_ready,
        output col_in, sel_s3, sel_s4, busy, out_valid, data_out, round_idx
    );

    modport master (
        output start, data_in, key, rounds, col_out, out_ready,
        input  col_in, sel_s3, sel_s4, busy, out_valid, data_out, round_idx
    );
endinterface

// File: rtl/column_round_ctrl.sv
// Round controller that iterates a 128-bit block through an external Column stage.
// Optional feature: define COLCTRL_ABORT_EN to add an abort input.
module column_round_ctrl #(
    parameter int MAX_ROUNDS = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef COLCTRL_ABORT_EN
    input  logic                abort,
`endif
    column_round_ctrl_if.slave  bus
);
    localparam int RW = $clog2(MAX_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e                  fsm_q,    fsm_d;
    logic [127:0]            blk_q,    blk_d;
    logic [2*MAX_ROUNDS-1:0] key_q,    key_d;
    logic [RW-1:0]           rounds_q, rounds_d;
    logic [RW-1:0]           ridx_q,   ridx_d;
    logic                    abort_s;
    logic [2*MAX_ROUNDS-1:0] key_sh_s;

`ifdef COLCTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Select pair of the current round sits in the two low bits after the shift.
    assign key_sh_s = key_q >> {ridx_q, 1'b0};

    // State register and job context; everything clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= IDLE;
            blk_q    <= 128'h0;
            key_q    <= '0;
            rounds_q <= '0;
            ridx_q   <= '0;
        end else begin
            fsm_q    <= fsm_d;
            blk_q    <= blk_d;
            key_q    <= key_d;
            rounds_q <= rounds_d;
            ridx_q   <= ridx_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        fsm_d    = fsm_q;
        blk_d    = blk_q;
        key_d    = key_q;
        rounds_d = rounds_q;
        ridx_d   = ridx_q;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    blk_d    = bus.data_in;
                    key_d    = bus.key;
                    rounds_d = bus.rounds;
                    ridx_d   = '0;
                    fsm_d    = LOAD;
                end else begin
                    fsm_d = IDLE;
                end
            end
            LOAD: begin
                if (abort_s) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d = RUN;
                end
            end
            RUN: begin
                if (abort_s) begin
                    fsm_d = IDLE;
                end else begin
                    blk_d = bus.col_out;
                    // Index parks on the last round so it never wraps mid-job.
                    if (ridx_q == rounds_q) begin
                        fsm_d = HOLD;
                    end else begin
                        ridx_d = ridx_q + RW'(1);
                        fsm_d  = RUN;
                    end
                end
            end
            HOLD: begin
                if (abort_s || bus.out_ready) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d = HOLD;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Output decode, all taken from registered state.
    always_comb begin
        bus.col_in    = blk_q;
        bus.data_out  = blk_q;
        bus.round_idx = ridx_q;
        bus.busy      = (fsm_q != IDLE);
        bus.out_valid = (fsm_q == HOLD);
        if (fsm_q == RUN) begin
            bus.sel_s3 = key_sh_s[1];
            bus.sel_s4 = key_sh_s[0];
        end else begin
            bus.sel_s3 = 1'b0;
            bus.sel_s4 = 1'b0;
        end
    end
endmodule

// File: tb/tb_column_round_ctrl.sv
// Self-checking bench for column_round_ctrl with a job-level reference model.
module tb_column_round_ctrl;
    localparam int MR = 8;
    localparam int RW = $clog2(MR);

    logic clk = 1'b0;
    logic rst;
    logic abort;
    always #5 clk = ~clk;

    column_round_ctrl_if #(.MAX_ROUNDS(MR)) bus ();

    column_round_ctrl #(.MAX_ROUNDS(MR)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef COLCTRL_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int sel_cycles = 0;

    // External Column stage: each 4-byte group is permuted by byte index XOR {s3,s4}.
    function automatic logic [127:0] perm(input logic [127:0] d, input logic [1:0] x);
        logic [127:0] r;
        r = 128'h0;
        for (int g = 0; g < 4; g++)
            for (int j = 0; j < 4; j++)
                r[8*(4*g+j) +: 8] = d[8*(4*g+(j ^ int'(x))) +: 8];
        return r;
    endfunction

    always_comb bus.col_out = perm(bus.col_in, {bus.sel_s3, bus.sel_s4});

    // Job-level model: t counts cycles since acceptance; the permutations compose by XOR.
    bit           m_act = 1'b0;
    int           m_t, m_R, m_ridx;
    logic [15:0]  m_key;
    logic [127:0] m_data, m_blk;

    function automatic logic [1:0] kp(input logic [15:0] k, input int r);
        logic [15:0] s;
        s = k >> (2*r);
        return s[1:0];
    endfunction

    function automatic logic [1:0] xr(input logic [15:0] k, input int n);
        logic [1:0] x;
        x = 2'b00;
        for (int i = 0; i < n; i++) x = x ^ kp(k, i);
        return x;
    endfunction

    function automatic logic [127:0] eblk(input int t);
        if (t == 1)            return m_data;
        else if (t <= m_R + 2) return perm(m_data, xr(m_key, t - 2));
        else                   return perm(m_data, xr(m_key, m_R + 1));
    endfunction

    function automatic int eridx(input int t);
        if (t <= 2)            return 0;
        else if (t <= m_R + 2) return t - 2;
        else                   return m_R;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic ab;
        logic [127:0] e_blk;
        logic [1:0]   e_sel;
        int           e_ridx;
        logic         e_busy, e_valid;
        @(posedge clk);
`ifdef COLCTRL_ABORT_EN
        ab = abort;
`else
        ab = 1'b0;
`endif
        if (rst) begin
            m_act = 1'b0; m_blk = 128'h0; m_ridx = 0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_act = 1'b1; m_t = 1; m_R = int'(bus.rounds);
                m_key = bus.key; m_data = bus.data_in;
            end
        end else if (ab) begin
            m_blk = eblk(m_t); m_ridx = eridx(m_t); m_act = 1'b0;
        end else if (m_t >= m_R + 3 && bus.out_ready) begin
            m_blk = eblk(m_t); m_ridx = m_R; m_act = 1'b0;
        end else begin
            m_t++;
        end
        @(negedge clk);
        if (!m_act) begin
            e_blk = m_blk; e_ridx = m_ridx; e_sel = 2'b00; e_busy = 1'b0; e_valid = 1'b0;
        end else begin
            e_blk = eblk(m_t); e_ridx = eridx(m_t); e_busy = 1'b1;
            e_valid = (m_t >= m_R + 3);
            e_sel = (m_t >= 2 && m_t <= m_R + 2) ? kp(m_key, m_t - 2) : 2'b00;
        end
        chk("col_in",    bus.col_in,    e_blk);
        chk("data_out",  bus.data_out,  e_blk);
        chk("round_idx", 128'(bus.round_idx), 128'(e_ridx));
        chk("busy",      128'(bus.busy),      128'(e_busy));
        chk("out_valid", 128'(bus.out_valid), 128'(e_valid));
        chk("sel",       128'({bus.sel_s3, bus.sel_s4}), 128'(e_sel));
        if (bus.sel_s3 || bus.sel_s4) sel_cycles++;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!bus.out_valid) chk("valid_timeout", 128'(bus.out_valid), 128'(1'b1));
    endtask

    task automatic launch(input logic [127:0] d, input logic [15:0] k, input int r, output int lat);
        int n;
        bus.data_in = d; bus.key = k; bus.rounds = RW'(r); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid(n);
        lat = n + 1;
    endtask

    localparam logic [127:0] SEQ = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] DA  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] DB  = 128'hdeadbeef_cafef00d_13579bdf_2468ace0;

    initial begin
        int lat;
        int n;
        rst = 1'b1; abort = 1'b0;
        bus.start = 1'b1; bus.data_in = DA; bus.key = 16'hffff; bus.rounds = RW'(3);
        bus.out_ready = 1'b0;
        tick(); tick();
        chk("rst_data_out", bus.data_out, 128'h0);
        chk("rst_busy", 128'(bus.busy), 128'h0);
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_start_ignored", 128'(bus.busy), 128'h0);

        // Single round with adjacent-byte swap.
        bus.out_ready = 1'b1;
        launch(SEQ, 16'h0001, 0, lat);
        chk("single_latency", 128'(lat), 128'd3);
        chk("single_data", bus.data_out, 128'h0e0f0c0d_0a0b0809_06070405_02030001);
        tick();
        chk("single_idle", 128'(bus.out_valid), 128'h0);

        // Involution with all-ones and all-zero selects.
        launch(DA, 16'h000f, 1, lat);
        chk("invol_ones", bus.data_out, DA);
        chk("invol_latency", 128'(lat), 128'd4);
        tick();
        launch(DB, 16'h0000, 1, lat);
        chk("invol_zeros", bus.data_out, DB);
        tick();

        // Back-pressure with input churn during the job.
        bus.out_ready = 1'b0;
        bus.data_in = DB; bus.key = 16'h0024; bus.rounds = RW'(2); bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.data_in = DA; bus.key = 16'hffff; bus.rounds = RW'(7);
        wait_valid(n);
        chk("bp_data", bus.data_out, perm(DB, 2'b11));
        for (int i = 0; i < 5; i++) begin
            bus.start = i[0];
            tick();
        end
        bus.start = 1'b0;
        chk("bp_valid_held", 128'(bus.out_valid), 128'h1);
        chk("bp_data_held", bus.data_out, perm(DB, 2'b11));
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release", 128'(bus.busy), 128'h0);

        // Full length with alternating selects.
        sel_cycles = 0;
        launch(DA, 16'h9999, MR - 1, lat);
        chk("full_run_cycles", 128'(sel_cycles), 128'(MR));
        chk("full_latency", 128'(lat), 128'(MR + 2));
        chk("full_data", bus.data_out, DA);
        chk("full_ridx", 128'(bus.round_idx), 128'(MR - 1));
        tick();

        // Reset in round 2, then a clean job.
        bus.data_in = DB; bus.key = 16'h0fa5; bus.rounds = RW'(5); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!(bus.sel_s3 || bus.sel_s4 || bus.round_idx != '0) && n < 10) begin tick(); n++; end
        while (bus.round_idx != RW'(2) && n < 20) begin tick(); n++; end
        chk("midrun_reached", 128'(bus.round_idx), 128'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_rst_busy", 128'(bus.busy), 128'h0);
        chk("midrun_rst_col", bus.col_in, 128'h0);
        chk("midrun_rst_ridx", 128'(bus.round_idx), 128'h0);
        launch(DA, 16'h00e4, 3, lat);
        chk("after_rst_data", bus.data_out, DA);
        tick();

`ifdef COLCTRL_ABORT_EN
        bus.out_ready = 1'b0;
        bus.data_in = DB; bus.key = 16'h0055; bus.rounds = RW'(4); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 128'(bus.busy), 128'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_valid", 128'(bus.out_valid), 128'h0);
        end
        abort = 1'b1; bus.start = 1'b1; bus.data_in = DA; bus.key = 16'h0003; bus.rounds = RW'(0);
        tick();
        abort = 1'b0; bus.start = 1'b0;
        chk("abort_start_taken", 128'(bus.busy), 128'h1);
        bus.out_ready = 1'b1;
        wait_valid(n);
        chk("abort_job_data", bus.data_out, perm(DA, 2'b11));
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
